// File: rtl/register_file_32x32_pkg.sv
// Shared constants for the 32x32 general register file.
package register_file_32x32_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int SP_IDX   = 29;
    localparam logic [DATA_W-1:0] SP_RESET = 32'h03ffffff;

    function automatic logic [NUM_REGS-1:0] dec_onehot(input logic [ADDR_W-1:0] a);
        dec_onehot    = '0;
        dec_onehot[a] = 1'b1;
    endfunction
endpackage

// File: rtl/register_file_32x32_reg32_ld.sv
// Load-enabled register with an async active-low reset to a per-instance reset value.
module reg32_ld #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= rst_val;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: 2 registered read ports, 1 write port, R0 hardwired zero,
// write-first bypass when a read and a write hit the same register on the same edge.
module register_file_32x32
    import register_file_32x32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_r1,
    input  logic [ADDR_W-1:0] addr_r2,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w,
    output logic [DATA_W-1:0] data_r1,
    output logic [DATA_W-1:0] data_r2,
    output logic              wr_ack
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             we;
    logic                            wr_ok;
    logic                            byp1, byp2;
    logic [DATA_W-1:0]               nxt1, nxt2;

    assign wr_ok = write && (addr_w != '0);

    // Gating by write keeps an unknown addr_w from reaching any load enable.
    always_comb begin
        we    = dec_onehot(addr_w) & {NUM_REGS{write}};
        we[0] = 1'b0;
    end

    assign regs[0] = '0;

    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_reg
            localparam logic [DATA_W-1:0] RV = (i == SP_IDX) ? SP_RESET : '0;
            reg32_ld #(.W(DATA_W)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .ld     (we[i]),
                .rst_val(RV),
                .d      (data_w),
                .q      (regs[i])
            );
        end
    endgenerate

    assign byp1 = read && wr_ok && (addr_r1 == addr_w);
    assign byp2 = read && wr_ok && (addr_r2 == addr_w);
    assign nxt1 = byp1 ? data_w : regs[addr_r1];
    assign nxt2 = byp2 ? data_w : regs[addr_r2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r1 <= '0;
            data_r2 <= '0;
            wr_ack  <= 1'b0;
        end else begin
            wr_ack <= wr_ok;
            if (read) begin
                data_r1 <= nxt1;
                data_r2 <= nxt2;
            end
        end
    end
endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares each cycle.
module tb_register_file_32x32;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b0, write = 1'b0;
    logic [4:0]  addr_r1 = '0, addr_r2 = '0, addr_w = '0;
    logic [31:0] data_w = '0;
    logic [31:0] data_r1, data_r2;
    logic        wr_ack;

    register_file_32x32 dut (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_w(addr_w), .data_w(data_w),
        .data_r1(data_r1), .data_r2(data_r2), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [32];
    logic [31:0] last1, last2;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        return (a == 0) ? 32'h0 : mdl[a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
        mdl[29] = 32'h03ffffff;
        last1 = '0;
        last2 = '0;
    endtask

    // One clock of stimulus; the register file updates before the read (write-first).
    task automatic cycle(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] dw);
        exp_t e;
        @(negedge clk);
        read = rd; write = wr; addr_r1 = a1; addr_r2 = a2; addr_w = aw; data_w = dw;
        e.ack = wr && (aw != 0);
        if (e.ack) mdl[aw] = dw;
        if (rd) begin
            last1 = mread(a1);
            last2 = mread(a2);
        end
        e.d1 = last1;
        e.d2 = last2;
        q.push_back(e);
    endtask

    // Reset asserted between edges; whatever was driven this cycle is lost.
    task automatic reset_now();
        #2;
        rst = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("rst_data_r1", data_r1, 32'h0);
        check("rst_data_r2", data_r2, 32'h0);
        check("rst_wr_ack", {31'h0, wr_ack}, 32'h0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst && q.size() > 0) begin
                e = q.pop_front();
                check("wr_ack", {31'h0, wr_ack}, {31'h0, e.ack});
                check("data_r1", data_r1, e.d1);
                check("data_r2", data_r2, e.d2);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        model_reset();
        #12;
        rst = 1'b1;
        // Reset contents, including SP
        for (int k = 0; k < 32; k++) cycle(1, 0, k[4:0], 5'(31 - k), 5'h0, 32'h0);
        // Fill R1..R31, then read all pairs
        for (int k = 1; k < 32; k++) cycle(0, 1, 5'h0, 5'h0, k[4:0], 32'hA5A5_0000 + k);
        for (int k = 0; k < 32; k++) cycle(1, 0, k[4:0], 5'(31 - k), 5'h0, 32'h0);
        // R0 write discarded
        cycle(0, 1, 5'h0, 5'h0, 5'h0, 32'hFFFF_FFFF);
        cycle(1, 0, 5'h0, 5'h0, 5'h0, 32'h0);
        // Bypass on both ports
        cycle(0, 1, 5'h0, 5'h0, 5'd5, 32'h1);
        cycle(1, 1, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF);
        cycle(1, 0, 5'd5, 5'd6, 5'h0, 32'h0);
        // Hold while the read target changes underneath
        cycle(0, 1, 5'h0, 5'h0, 5'd7, 32'h7);
        cycle(1, 0, 5'd7, 5'd7, 5'h0, 32'h0);
        cycle(0, 1, 5'd3, 5'd4, 5'd7, 32'h8);
        cycle(0, 0, 5'd9, 5'd9, 5'd9, 32'h1234);
        cycle(1, 0, 5'd7, 5'd0, 5'h0, 32'h0);
        // Randomized traffic
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom);
        // Reset in the middle of a write burst
        cycle(1, 1, 5'd3, 5'd29, 5'd3, 32'h3333_3333);
        cycle(0, 1, 5'd0, 5'd0, 5'd4, 32'h4444_4444);
        reset_now();
        cycle(0, 0, 5'h0, 5'h0, 5'h0, 32'h0);
        for (int k = 0; k < 32; k++) cycle(1, 0, k[4:0], 5'(31 - k), 5'h0, 32'h0);
        // Resume cleanly after reset
        cycle(0, 1, 5'h0, 5'h0, 5'd4, 32'h0BAD_F00D);
        cycle(1, 1, 5'd4, 5'd29, 5'd29, 32'h1000_0000);
        cycle(1, 0, 5'd29, 5'd4, 5'h0, 32'h0);
        cycle(0, 0, 5'h0, 5'h0, 5'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
